// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling, LSB first.
// Bytes leave on a valid/ready handshake; frame_err/overrun are 1-cycle pulses.
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BAUD_TICKS / 2;
  localparam int CW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          ovr_q;

  // Sync the pin, run the frame FSM and register every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;

      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
            end else begin
              bit_q   <= '0;
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q          <= '0;
            shift_q[bit_q] <= rx_s_q;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              // An accept on this same edge frees the slot.
              if (!valid_q || ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
